alu_arbiter: RTL and testbench

Shares a single ALU datapath (AND/OR/XOR/ADD/SUB/EQ/NE/LTU/SLL/SRL/SRA, 4-bit operation code) between two requesters. Port 0 is the pipeline EX stage and port 1 is an auxiliary multi-cycle unit. Each port has a valid/ready request channel and a one-entry registered response buffer with its own valid/ready. Arbitration is round-robin, and total throughput is one operation per cycle.

---
 rtl/alu_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Purpose: shares one combinational ALU between two requesters. Port 0 is the
// pipeline EX stage, port 1 an auxiliary multi-cycle unit. Each port has a
// valid/ready request channel and a one-entry registered response buffer
// with its own rvalid/rready handshake. A 1-bit round-robin pointer settles
// ties, so at most one request is accepted per cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pX_valid / pX_ready        request handshake (accept = valid && ready)
//   pX_srca, pX_srcb, pX_op    request payload, sampled only on accept
//   pX_rvalid / pX_rready      response handshake (rvalid = buffer FULL)
//   pX_result                  buffered result, held until the next accept
//   conflict_cnt               saturating contention counter
//
// Configuration macro: ALU_ARB_STATS_EN adds the conflict_cnt output and its
// counter. Without it the port and logic are absent.

module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     p0_valid,
    output logic                     p0_ready,
    input  logic [DATA_WIDTH-1:0]    p0_srca,
    input  logic [DATA_WIDTH-1:0]    p0_srcb,
    input  logic [OPCODE_LENGTH-1:0] p0_op,
    output logic                     p0_rvalid,
    input  logic                     p0_rready,
    output logic [DATA_WIDTH-1:0]    p0_result,
    input  logic                     p1_valid,
    output logic                     p1_ready,
    input  logic [DATA_WIDTH-1:0]    p1_srca,
    input  logic [DATA_WIDTH-1:0]    p1_srcb,
    input  logic [OPCODE_LENGTH-1:0] p1_op,
    output logic                     p1_rvalid,
    input  logic                     p1_rready,
    output logic [DATA_WIDTH-1:0]    p1_result
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]              conflict_cnt
`endif
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(4'b1110);
    localparam logic [OPCODE_LENGTH-1:0] OP_LTU = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t p0_state, p0_state_next;
    buf_state_t p1_state, p1_state_next;

    // last = 1 means port 1 won most recently, so the next tie goes to port 0
    logic last;
    logic p0_elig, p1_elig;
    logic p0_grant, p1_grant;

    logic [DATA_WIDTH-1:0]    alu_a, alu_b, alu_y;
    logic [OPCODE_LENGTH-1:0] alu_op;

    // A port may be granted when its buffer is free now or is being drained
    // this very cycle. Ties go to whichever port did not win last time.
    // Only valid, buffer state, rready and last feed this path.
    always_comb begin
        p0_elig  = p0_valid && ((p0_state == EMPTY) || p0_rready);
        p1_elig  = p1_valid && ((p1_state == EMPTY) || p1_rready);
        p0_grant = 1'b0;
        p1_grant = 1'b0;
        if (p0_elig && p1_elig) begin
            p0_grant = last;
            p1_grant = ~last;
        end else begin
            p0_grant = p0_elig;
            p1_grant = p1_elig;
        end
    end

    assign p0_ready = p0_grant;
    assign p1_ready = p1_grant;

    // The single ALU sees the granted port's payload; when nothing is
    // granted it sees port 0, whose result is then simply not stored.
    assign alu_a  = p1_grant ? p1_srca : p0_srca;
    assign alu_b  = p1_grant ? p1_srcb : p0_srcb;
    assign alu_op = p1_grant ? p1_op   : p0_op;

    // Logical shifts use the whole srcb, so oversized amounts give zero.
    // SRA deliberately looks only at srcb[4:0].
    always_comb begin
        alu_y = '0;
        case (alu_op)
            OP_AND: alu_y = alu_a & alu_b;
            OP_OR:  alu_y = alu_a | alu_b;
            OP_XOR: alu_y = alu_a ^ alu_b;
            OP_ADD: alu_y = alu_a + alu_b;
            OP_SUB: alu_y = alu_a - alu_b;
            OP_EQ:  alu_y = DATA_WIDTH'(alu_a == alu_b);
            OP_NE:  alu_y = DATA_WIDTH'(alu_a != alu_b);
            OP_LTU: alu_y = DATA_WIDTH'(alu_a < alu_b);
            OP_SLL: alu_y = (alu_b >= DATA_WIDTH'(DATA_WIDTH)) ? '0 : (alu_a << alu_b);
            OP_SRL: alu_y = (alu_b >= DATA_WIDTH'(DATA_WIDTH)) ? '0 : (alu_a >> alu_b);
            OP_SRA: alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_y = '0;
        endcase
    end

    // Buffer next state: an accept always leaves the buffer FULL (a drain in
    // the same cycle is replaced by the reload); otherwise rready empties it.
    always_comb begin
        p0_state_next = p0_state;
        p1_state_next = p1_state;
        if (p0_grant) begin
            p0_state_next = FULL;
        end else if (p0_rready) begin
            p0_state_next = EMPTY;
        end
        if (p1_grant) begin
            p1_state_next = FULL;
        end else if (p1_rready) begin
            p1_state_next = EMPTY;
        end
    end

    // State, result buffers and round-robin pointer. Results are only
    // written on accept, so they keep the last value once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_state  <= EMPTY;
            p1_state  <= EMPTY;
            p0_result <= '0;
            p1_result <= '0;
            last      <= 1'b1;
        end else begin
            p0_state <= p0_state_next;
            p1_state <= p1_state_next;
            if (p0_grant) begin
                p0_result <= alu_y;
                last      <= 1'b0;
            end
            if (p1_grant) begin
                p1_result <= alu_y;
                last      <= 1'b1;
            end
        end
    end

    assign p0_rvalid = (p0_state == FULL);
    assign p1_rvalid = (p1_state == FULL);

`ifdef ALU_ARB_STATS_EN
    logic conflict;

    assign conflict = (p0_valid && !p0_grant) || (p1_valid && !p1_grant);

    // Counts cycles where some requester waits; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//
// Directed testbench for alu_arbiter: reset behaviour, back-to-back single
// port traffic, alternating contention, a stalled response buffer, the ALU
// operation table and, when ALU_ARB_STATS_EN is defined, the contention
// counter including saturation.

module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_valid, p0_ready, p0_rvalid, p0_rready;
    logic [31:0] p0_srca, p0_srcb, p0_result;
    logic [3:0]  p0_op;
    logic        p1_valid, p1_ready, p1_rvalid, p1_rready;
    logic [31:0] p1_srca, p1_srcb, p1_result;
    logic [3:0]  p1_op;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    // Hand-computed ALU vectors, issued back to back on port 0
    vec_t vecs [0:19] = '{
        '{4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00},
        '{4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F},
        '{4'b1001, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F},
        '{4'b0010, 32'hFFFFFFFF, 32'h00000002, 32'h00000001},
        '{4'b0110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE},
        '{4'b1000, 32'h00000003, 32'h00000003, 32'h00000001},
        '{4'b1000, 32'h00000003, 32'h00000004, 32'h00000000},
        '{4'b1110, 32'h00000003, 32'h00000003, 32'h00000000},
        '{4'b1110, 32'h00000003, 32'h00000004, 32'h00000001},
        '{4'b1100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
        '{4'b1100, 32'h00000001, 32'hFFFFFFFF, 32'h00000001},
        '{4'b0100, 32'h00000001, 32'h00000020, 32'h00000000},
        '{4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000},
        '{4'b0100, 32'h00000001, 32'h00000040, 32'h00000000},
        '{4'b0101, 32'h80000000, 32'h00000004, 32'h08000000},
        '{4'b0101, 32'h80000000, 32'h00000021, 32'h00000000},
        '{4'b0111, 32'h80000000, 32'h00000024, 32'hF8000000},
        '{4'b0111, 32'h40000000, 32'h00000002, 32'h10000000},
        '{4'b0011, 32'h00000005, 32'h00000006, 32'h00000000},
        '{4'b1111, 32'h00000005, 32'h00000006, 32'h00000000}
    };

    alu_arbiter #(
        .DATA_WIDTH    (32),
        .OPCODE_LENGTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_srca   (p0_srca),
        .p0_srcb   (p0_srcb),
        .p0_op     (p0_op),
        .p0_rvalid (p0_rvalid),
        .p0_rready (p0_rready),
        .p0_result (p0_result),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_srca   (p1_srca),
        .p1_srcb   (p1_srcb),
        .p1_op     (p1_op),
        .p1_rvalid (p1_rvalid),
        .p1_rready (p1_rready),
        .p1_result (p1_result)
`ifdef ALU_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive both request channels and both rready lines, then let the
    // combinational ready settle before anything is sampled.
    task automatic applyStimulus(
        input logic v0, input logic [31:0] a0, input logic [31:0] b0,
        input logic [3:0] op0, input logic rr0,
        input logic v1, input logic [31:0] a1, input logic [31:0] b1,
        input logic [3:0] op1, input logic rr1);
        p0_valid  = v0;
        p0_srca   = a0;
        p0_srcb   = b0;
        p0_op     = op0;
        p0_rready = rr0;
        p1_valid  = v1;
        p1_srca   = a1;
        p1_srcb   = b1;
        p1_op     = op1;
        p1_rready = rr1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k0;
        int k1;
        logic g0;

        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        checkOutput("reset_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        checkOutput("reset_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
        checkOutput("reset_p0_result", p0_result, 32'd0);
        checkOutput("reset_p1_result", p1_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] fill p0 with 0x5 then reset asynchronously");
        applyStimulus(1, 32'h5, 32'h0, 4'b0001, 0, 0, 0, 0, 4'b0000, 0);
        checkOutput("fill_p0_ready", {31'b0, p0_ready}, 32'd1);
        tick();
        applyStimulus(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        checkOutput("fill_p0_rvalid", {31'b0, p0_rvalid}, 32'd1);
        checkOutput("fill_p0_result", p0_result, 32'h5);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        checkOutput("async_rst_p0_result", p0_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] contention, eight requests per port");
        k0 = 0;
        k1 = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(k0 < 8, 32'(k0), 32'd100, 4'b0010, 1,
                          k1 < 8, 32'd1000, 32'(k1), 4'b0110, 1);
            g0 = ((i % 2) == 0);
            checkOutput($sformatf("rr_p0_ready_%0d", i), {31'b0, p0_ready}, {31'b0, g0});
            checkOutput($sformatf("rr_p1_ready_%0d", i), {31'b0, p1_ready}, {31'b0, ~g0});
            tick();
            if (g0) begin
                checkOutput($sformatf("rr_p0_rvalid_%0d", i), {31'b0, p0_rvalid}, 32'd1);
                checkOutput($sformatf("rr_p0_result_%0d", i), p0_result, 32'(k0 + 100));
                k0++;
            end else begin
                checkOutput($sformatf("rr_p1_rvalid_%0d", i), {31'b0, p1_rvalid}, 32'd1);
                checkOutput($sformatf("rr_p1_result_%0d", i), p1_result, 32'(1000 - k1));
                k1++;
            end
        end

        $display("[TB] back-to-back on p0");
        applyStimulus(1, 32'h7FFFFFFF, 32'h1, 4'b0010, 1, 0, 0, 0, 4'b0000, 1);
        checkOutput("b2b_ready_0", {31'b0, p0_ready}, 32'd1);
        tick();
        checkOutput("b2b_rvalid_0", {31'b0, p0_rvalid}, 32'd1);
        checkOutput("b2b_result_0", p0_result, 32'h80000000);
        applyStimulus(1, 32'h0, 32'h1, 4'b0110, 1, 0, 0, 0, 4'b0000, 1);
        checkOutput("b2b_ready_1", {31'b0, p0_ready}, 32'd1);
        tick();
        checkOutput("b2b_rvalid_1", {31'b0, p0_rvalid}, 32'd1);
        checkOutput("b2b_result_1", p0_result, 32'hFFFFFFFF);
        applyStimulus(1, 32'h80000000, 32'h404, 4'b0111, 1, 0, 0, 0, 4'b0000, 1);
        checkOutput("b2b_ready_2", {31'b0, p0_ready}, 32'd1);
        tick();
        checkOutput("b2b_rvalid_2", {31'b0, p0_rvalid}, 32'd1);
        checkOutput("b2b_result_2", p0_result, 32'hF8000000);

        $display("[TB] stalled p1 buffer");
        applyStimulus(0, 0, 0, 4'b0000, 1, 1, 32'hF0F0, 32'hFF00, 4'b0000, 0);
        checkOutput("stall_fill_ready", {31'b0, p1_ready}, 32'd1);
        tick();
        checkOutput("stall_fill_rvalid", {31'b0, p1_rvalid}, 32'd1);
        checkOutput("stall_fill_result", p1_result, 32'h0000F000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'(i), 32'h100, 4'b0001, 1,
                          1, 32'hAAAA, 32'h5555, 4'b1001, 0);
            checkOutput($sformatf("stall_p1_ready_%0d", i), {31'b0, p1_ready}, 32'd0);
            checkOutput($sformatf("stall_p0_ready_%0d", i), {31'b0, p0_ready}, 32'd1);
            tick();
            checkOutput($sformatf("stall_p0_result_%0d", i), p0_result, 32'(i) | 32'h100);
            checkOutput($sformatf("stall_p1_result_%0d", i), p1_result, 32'h0000F000);
            checkOutput($sformatf("stall_p1_rvalid_%0d", i), {31'b0, p1_rvalid}, 32'd1);
        end
        applyStimulus(1, 32'h3, 32'h100, 4'b0001, 1, 1, 32'hAAAA, 32'h5555, 4'b1001, 1);
        checkOutput("drain_p1_ready", {31'b0, p1_ready}, 32'd1);
        checkOutput("drain_p0_ready", {31'b0, p0_ready}, 32'd0);
        tick();
        checkOutput("drain_p1_rvalid", {31'b0, p1_rvalid}, 32'd1);
        checkOutput("drain_p1_result", p1_result, 32'h0000FFFF);
        applyStimulus(0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        tick();
        checkOutput("hold_p1_rvalid", {31'b0, p1_rvalid}, 32'd1);
        checkOutput("hold_p1_result", p1_result, 32'h0000FFFF);

        $display("[TB] ALU operation table");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, vecs[i].a, vecs[i].b, vecs[i].op, 1, 0, 0, 0, 4'b0000, 0);
            tick();
            checkOutput($sformatf("alu_op%b_%0d", vecs[i].op, i), p0_result, vecs[i].exp);
        end
        applyStimulus(0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        tick();
        checkOutput("alu_drained_rvalid", {31'b0, p0_rvalid}, 32'd0);
        checkOutput("alu_drained_result", p0_result, 32'h0);

`ifdef ALU_ARB_STATS_EN
        $display("[TB] contention counter");
        rst_n = 1'b0;
        #1;
        checkOutput("cnt_reset", {16'b0, conflict_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("cnt_idle", {16'b0, conflict_cnt}, 32'd0);
        applyStimulus(1, 32'h1, 32'h1, 4'b0010, 1, 1, 32'h2, 32'h2, 4'b0010, 1);
        repeat (10) tick();
        checkOutput("cnt_ten", {16'b0, conflict_cnt}, 32'd10);
        repeat (70000) @(posedge clk);
        #1;
        checkOutput("cnt_saturated", {16'b0, conflict_cnt}, 32'h0000FFFF);
        applyStimulus(0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
